// File: rtl/quad_decoder_multi_if.sv
// Purpose : bundle of the per-channel encoder pins, controls and decoded outputs for quad_decoder_multi.
// Latency : none (wires only).
// Backpressure: none; all signals are free-running levels or one-cycle pulses.
// Ports   : enc_in  {b1,b0} pairs per channel, pos_clr / err_clr per channel (master drives),
//           pos_out packed POS_W per channel, step_cw / step_ccw pulses, err sticky flags (slave drives).
interface quad_decoder_multi_if #(
    parameter int CHANNELS = 2,
    parameter int POS_W    = 8
);
    logic [2*CHANNELS-1:0]     enc_in;
    logic [CHANNELS-1:0]       pos_clr;
    logic [CHANNELS-1:0]       err_clr;
    logic [CHANNELS*POS_W-1:0] pos_out;
    logic [CHANNELS-1:0]       step_cw;
    logic [CHANNELS-1:0]       step_ccw;
    logic [CHANNELS-1:0]       err;

    // Master: whatever sits on the pin side (board / bench).
    modport master (
        output enc_in, pos_clr, err_clr,
        input  pos_out, step_cw, step_ccw, err
    );

    // Slave: the decoder itself.
    modport slave (
        input  enc_in, pos_clr, err_clr,
        output pos_out, step_cw, step_ccw, err
    );
endinterface

// File: rtl/quad_decoder_multi.sv
// Purpose : multi-channel quadrature decoder: sync, debounce, Gray decode (x1/x4), wrap/saturate position, step pulses.
// Latency : stable raw level -> pos/step update in 2 + DEB_CYCLES + 1 clk cycles.
// Backpressure: none; pulses are single-cycle and outputs are never stalled.
// Ports   : clk, rst (async, active-high); bus (quad_decoder_multi_if.slave) carrying enc_in, pos_clr,
//           err_clr, pos_out, step_cw, step_ccw, err.
// Build option: define QDEC_ERR_EN to enable the sticky illegal-transition flag; otherwise err is tied
//           low and err_clr is ignored.
module quad_decoder_multi #(
    parameter int CHANNELS   = 2,
    parameter int POS_W      = 8,
    parameter int DEB_CYCLES = 16,
    parameter int X4_MODE    = 0,
    parameter int SATURATE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    quad_decoder_multi_if.slave  bus
);

    // Counter only has to reach DEB_CYCLES-1: the flip happens on the DEB_CYCLES-th differing cycle.
    localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_MAX  = '1;
    localparam bit X4  = (X4_MODE != 0);
    localparam bit SAT = (SATURATE != 0);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]            sync1;
        logic [1:0]            sync2;
        logic [1:0]            deb;
        logic [1:0]            prev;
        logic [1:0][CNT_W-1:0] deb_cnt;
        logic [POS_W-1:0]      pos;
        logic                  step_cw_q;
        logic                  step_ccw_q;

        logic [3:0] trans;
        logic       is_cw;
        logic       is_ccw;
        logic       is_ill;
        logic       cnt_cw;
        logic       cnt_ccw;

        // Transition classification on {prev, cur}. Encoding is {b1,b0}.
        always_comb begin
            trans  = {prev, deb};
            is_cw  = 1'b0;
            is_ccw = 1'b0;
            is_ill = 1'b0;
            case (trans)
                4'b0001, 4'b0111, 4'b1110, 4'b1000: is_cw  = 1'b1;
                4'b0010, 4'b1011, 4'b1101, 4'b0100: is_ccw = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: is_ill = 1'b1;
                default: ;
            endcase
            // x1 counts only the return to the 00 detent.
            if (X4) begin
                cnt_cw  = is_cw;
                cnt_ccw = is_ccw;
            end else begin
                cnt_cw  = (trans == 4'b1000);
                cnt_ccw = (trans == 4'b0100);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1      <= '0;
                sync2      <= '0;
                deb        <= '0;
                prev       <= '0;
                deb_cnt    <= '0;
                pos        <= '0;
                step_cw_q  <= 1'b0;
                step_ccw_q <= 1'b0;
            end else begin
                sync1 <= bus.enc_in[2*ch +: 2];
                sync2 <= sync1;

                // Each bit debounces independently; any cycle of agreement restarts the count.
                for (int b = 0; b < 2; b++) begin
                    if (sync2[b] == deb[b]) begin
                        deb_cnt[b] <= '0;
                    end else if (deb_cnt[b] == CNT_LAST) begin
                        deb[b]     <= sync2[b];
                        deb_cnt[b] <= '0;
                    end else begin
                        deb_cnt[b] <= deb_cnt[b] + CNT_W'(1);
                    end
                end

                prev <= deb;

                // Pulses reflect the decoded step even when the position is held or cleared.
                step_cw_q  <= cnt_cw;
                step_ccw_q <= cnt_ccw;

                if (bus.pos_clr[ch]) begin
                    pos <= '0;
                end else if (cnt_cw) begin
                    if (!(SAT && pos == POS_MAX)) begin
                        pos <= pos + POS_W'(1);
                    end
                end else if (cnt_ccw) begin
                    if (!(SAT && pos == '0)) begin
                        pos <= pos - POS_W'(1);
                    end
                end
            end
        end

        assign bus.pos_out[ch*POS_W +: POS_W] = pos;
        assign bus.step_cw[ch]  = step_cw_q;
        assign bus.step_ccw[ch] = step_ccw_q;

`ifdef QDEC_ERR_EN
        logic err_q;

        // A fresh illegal transition beats a clear arriving in the same cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_q <= 1'b0;
            end else if (is_ill) begin
                err_q <= 1'b1;
            end else if (bus.err_clr[ch]) begin
                err_q <= 1'b0;
            end
        end

        assign bus.err[ch] = err_q;
`else
        logic unused_ill;
        assign unused_ill  = is_ill;
        assign bus.err[ch] = 1'b0;
`endif
    end

`ifndef QDEC_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = ^bus.err_clr;
`endif

endmodule
